operand_loader: RTL and testbench

Upstream stage of the 4-bit adder (`eq4`) on the board build. It synchronises and debounces the two push buttons and the slide switches, and turns each accepted press into a one-cycle strobe. On each strobe it latches the switch value into operand register A (`btn[0]`) or B (`btn[1]`). The adder consumes `op_a`/`op_b` directly, with `upd` as the recompute strobe.

---
 rtl/loader_pkg.sv | 17 +
 rtl/btn_debounce.sv | 113 +++++++++++
 rtl/operand_loader.sv | 80 ++++++++
 tb/tb_operand_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the operand loader: debounce FSM states and
// counter sizing.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } db_state_t;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, debounce FSM with a saturating
// stable-sample counter, and a registered one-cycle press strobe.
module btn_debounce
  import loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press,
  output logic press_next
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          level;
  logic [CW-1:0] cnt_inc;
  logic          stable_done;

  assign level = sync_q[1];

  // cnt_q counts stable samples already seen; cnt_inc includes the current
  // one, so acceptance lands on the DEBOUNCE_CYCLES-th stable sample.
  assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign stable_done = (cnt_inc >= CNT_DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d  = {sync_q[0], btn};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level) begin
          if (stable_done) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = WAIT_PRESS;
            cnt_d   = cnt_inc;
          end
        end
      end
      WAIT_PRESS: begin
        if (!level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!level) begin
          if (stable_done) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_RELEASE;
            cnt_d   = cnt_inc;
          end
        end
      end
      WAIT_RELEASE: begin
        if (level) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press      = press_q;
  assign press_next = press_d;

endmodule

// File: rtl/operand_loader.sv
// Board front end for the 4-bit adder: debounced buttons latch the synchronised
// switches into operand A/B and raise a registered recompute strobe.
module operand_loader
  import loader_pkg::*;
#(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic [1:0]   btn,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [1:0]   press,
  output logic         a_loaded,
  output logic         b_loaded,
  output logic         valid,
  output logic         upd
);

  logic [W-1:0] sw_s1_q, sw_s2_q;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic         a_loaded_q, a_loaded_d, b_loaded_q, b_loaded_d;
  logic         upd_q, upd_d;
  logic [1:0]   press_q, press_next;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn[i]),
      .press     (press_q[i]),
      .press_next(press_next[i])
    );
  end

  // Operands load on the same edge the press strobe rises, so both become
  // visible together.
  always_comb begin
    op_a_d     = press_next[0] ? sw_s2_q : op_a_q;
    op_b_d     = press_next[1] ? sw_s2_q : op_b_q;
    a_loaded_d = a_loaded_q | press_next[0];
    b_loaded_d = b_loaded_q | press_next[1];
    upd_d      = (|press_q) & a_loaded_q & b_loaded_q;
  end

  // NOTE: these are plain registers, not a memory, so all of them take the
  // async reset and come up at a defined value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      a_loaded_q <= 1'b0;
      b_loaded_q <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      a_loaded_q <= a_loaded_d;
      b_loaded_q <= b_loaded_d;
      upd_q      <= upd_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign press    = press_q;
  assign a_loaded = a_loaded_q;
  assign b_loaded = b_loaded_q;
  assign valid    = a_loaded_q & b_loaded_q;
  assign upd      = upd_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES = 4 and W = 4.
module tb_operand_loader;

  localparam int W  = 4;
  localparam int DB = 4;
  // Input set just after edge e is sampled at e+1; strobe visible after e+1+1+DB.
  localparam int PRESS_TICKS = DB + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [1:0]   btn;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   press;
  logic         a_loaded, b_loaded, valid, upd;

  int total = 0;
  int bad   = 0;
  int cnt_p0 = 0, cnt_p1 = 0, cnt_upd = 0;

  operand_loader #(.W(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .btn     (btn),
    .op_a    (op_a),
    .op_b    (op_b),
    .press   (press),
    .a_loaded(a_loaded),
    .b_loaded(b_loaded),
    .valid   (valid),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      cnt_p0  += int'(press[0]);
      cnt_p1  += int'(press[1]);
      cnt_upd += int'(upd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ticks until press[idx] is seen; n = -1 if the budget runs out.
  task automatic wait_press(input int idx, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (press[idx]) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic release_all();
    btn = 2'b00;
    tick(12);
  endtask

  int n, p0_before, p1_before, upd_before;

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    btn   = 2'b00;
    tick(2);

    // 1. Reset values, then reset mid-count with btn[0] held
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_press", press, 0);
    check("rst_flags", {a_loaded, b_loaded, valid, upd}, 0);
    rst_n = 1'b1;
    sw    = 4'b0011;
    btn   = 2'b01;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {op_a, op_b, press, a_loaded, b_loaded, valid, upd}, 0);
    #1 rst_n = 1'b1;
    wait_press(0, 20, n);
    check("rst_hold_latency", n, PRESS_TICKS);
    check("rst_hold_op_a", op_a, 4'b0011);
    check("rst_hold_a_loaded", a_loaded, 1);
    tick();
    check("rst_hold_strobe_width", press, 0);
    check("rst_hold_no_upd", upd, 0);
    release_all();

    // 2. Clean loads of A then B
    sw  = 4'b0100;
    btn = 2'b01;
    wait_press(0, 20, n);
    check("a_latency", n, PRESS_TICKS);
    check("a_press", press, 2'b01);
    check("a_op_a", op_a, 4'b0100);
    check("a_valid", valid, 0);
    tick();
    check("a_press_width", press, 0);
    check("a_no_upd", upd, 0);
    release_all();

    sw  = 4'b0101;
    btn = 2'b10;
    wait_press(1, 20, n);
    check("b_latency", n, PRESS_TICKS);
    check("b_press", press, 2'b10);
    check("b_op_b", op_b, 4'b0101);
    check("b_op_a_kept", op_a, 4'b0100);
    check("b_valid", valid, 1);
    check("b_upd_not_yet", upd, 0);
    tick();
    check("b_upd", upd, 1);
    check("b_press_width", press, 0);
    tick();
    check("b_upd_width", upd, 0);
    release_all();

    // 3. Bounce on press and on release
    p0_before = cnt_p0;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~i[0];
      tick(2);
    end
    check("bounce_no_early_press", cnt_p0 - p0_before, 0);
    btn[0] = 1'b1;
    wait_press(0, 40, n);
    check("bounce_latency", n, PRESS_TICKS);
    check("bounce_op_a", op_a, 4'b0101);
    tick(10);
    for (int i = 0; i < 10; i++) begin
      btn[0] = i[0];
      tick(2);
    end
    release_all();
    check("bounce_one_press", cnt_p0 - p0_before, 1);

    // 4. Long hold then re-press
    p1_before = cnt_p1;
    btn = 2'b10;
    tick(100);
    check("hold_one_press", cnt_p1 - p1_before, 1);
    release_all();
    sw  = 4'b1100;
    btn = 2'b10;
    wait_press(1, 20, n);
    check("repress_latency", n, PRESS_TICKS);
    check("repress_op_b", op_b, 4'b1100);
    tick();
    check("repress_upd", upd, 1);
    check("repress_count", cnt_p1 - p1_before, 2);
    release_all();

    // 5. Simultaneous press
    upd_before = cnt_upd;
    sw  = 4'b0110;
    btn = 2'b11;
    wait_press(0, 20, n);
    check("both_latency", n, PRESS_TICKS);
    check("both_press", press, 2'b11);
    check("both_op_a", op_a, 4'b0110);
    check("both_op_b", op_b, 4'b0110);
    tick();
    check("both_upd", upd, 1);
    check("both_press_width", press, 0);
    tick();
    check("both_upd_width", upd, 0);
    release_all();
    check("both_single_upd", cnt_upd - upd_before, 1);

    // 6. Switch changes without a press
    upd_before = cnt_upd;
    p0_before  = cnt_p0;
    p1_before  = cnt_p1;
    sw = 4'b1111;
    tick(5);
    sw = 4'b0001;
    tick(5);
    check("sw_only_op_a", op_a, 4'b0110);
    check("sw_only_op_b", op_b, 4'b0110);
    check("sw_only_no_upd", cnt_upd - upd_before, 0);
    check("sw_only_no_press", (cnt_p0 - p0_before) + (cnt_p1 - p1_before), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
